// File: rtl/nf10_rx_len_stamper_if.sv
// AXI-Stream bundle used on both sides of the RX length stamper.
interface nf10_rx_len_stamper_if #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_rx_len_stamper.sv
// Store-and-forward RX stage: buffers whole packets, stamps the byte count into tuser[15:0]
// and discards packets longer than C_MAX_PKT_BEATS beats.
module nf10_rx_len_stamper #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_DATA_FIFO_DEPTH  = 64,
    parameter int unsigned C_LEN_FIFO_DEPTH   = 16,
    parameter int unsigned C_MAX_PKT_BEATS    = 48
) (
    input  logic                  axi_aclk,
    input  logic                  axi_reset,
    nf10_rx_len_stamper_if.slave  s_axis,
    nf10_rx_len_stamper_if.master m_axis,
    output logic [31:0]           drop_cnt
);
    localparam int unsigned StrbW  = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned EntryW = C_AXIS_DATA_WIDTH + StrbW + 1;
    localparam int unsigned DAw    = $clog2(C_DATA_FIFO_DEPTH);
    localparam int unsigned LAw    = $clog2(C_LEN_FIFO_DEPTH);
    localparam int unsigned BeatW  = $clog2(C_MAX_PKT_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StAcc, StDrop} in_state_e;

    in_state_e state_q, state_d;

    logic [EntryW-1:0]             data_mem [C_DATA_FIFO_DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] desc_mem [C_LEN_FIFO_DEPTH];

    logic [DAw:0]                  wr_spec_q, wr_spec_d;
    logic [DAw:0]                  wr_com_q, wr_com_d;
    logic [DAw:0]                  rd_q;
    logic [LAw:0]                  desc_wr_q, desc_ld_q, desc_rd_q;
    logic [15:0]                   byte_cnt_q, byte_cnt_d, bytes_next;
    logic [BeatW-1:0]              beat_cnt_q, beat_cnt_d, beats_next;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d, tuser_sel, desc_wdata;
    logic                          rst_done_q;
    logic                          data_we, desc_we, drop_inc;
    logic                          data_full, data_empty, desc_full, desc_avail;
    logic                          in_ready, in_fire, load, out_pop;
    logic [EntryW-1:0]             rd_entry;

    logic                          m_valid_q, m_last_q;
    logic [C_AXIS_DATA_WIDTH-1:0]  m_data_q;
    logic [StrbW-1:0]              m_strb_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] m_user_q;

    function automatic logic [15:0] popcount(input logic [StrbW-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < StrbW; i++) begin
            n = n + {15'd0, v[i]};
        end
        return n;
    endfunction

    // Full is taken against the speculative pointer so a partial packet can't overrun stored data.
    assign data_full  = (wr_spec_q - rd_q) == (DAw + 1)'(C_DATA_FIFO_DEPTH);
    assign data_empty = (wr_com_q == rd_q);
    assign desc_full  = (desc_wr_q - desc_rd_q) == (LAw + 1)'(C_LEN_FIFO_DEPTH);
    assign desc_avail = (desc_wr_q != desc_ld_q);

    assign in_ready = ~axi_reset &
                      ((state_q == StDrop) | (rst_done_q & ~data_full & ~desc_full));
    assign in_fire  = s_axis.tvalid & in_ready;
    assign s_axis.tready = in_ready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        beat_cnt_d = beat_cnt_q;
        tuser_d    = tuser_q;
        wr_spec_d  = wr_spec_q;
        wr_com_d   = wr_com_q;
        data_we    = 1'b0;
        desc_we    = 1'b0;
        drop_inc   = 1'b0;
        bytes_next = byte_cnt_q + popcount(s_axis.tstrb);
        beats_next = beat_cnt_q + BeatW'(1);
        tuser_sel  = (state_q == StIdle) ? s_axis.tuser : tuser_q;
        desc_wdata = tuser_sel;
        desc_wdata[15:0] = bytes_next;

        case (state_q)
            StIdle, StAcc: begin
                if (in_fire) begin
                    data_we    = 1'b1;
                    wr_spec_d  = wr_spec_q + (DAw + 1)'(1);
                    byte_cnt_d = bytes_next;
                    beat_cnt_d = beats_next;
                    tuser_d    = tuser_sel;
                    if (s_axis.tlast) begin
                        wr_com_d   = wr_spec_q + (DAw + 1)'(1);
                        desc_we    = 1'b1;
                        byte_cnt_d = '0;
                        beat_cnt_d = '0;
                        state_d    = StIdle;
                    end else if (beats_next == BeatW'(C_MAX_PKT_BEATS)) begin
                        // Oversize: rewind to the last committed packet and swallow the rest.
                        wr_spec_d  = wr_com_q;
                        byte_cnt_d = '0;
                        beat_cnt_d = '0;
                        state_d    = StDrop;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StDrop: begin
                if (in_fire && s_axis.tlast) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            beat_cnt_q <= '0;
            tuser_q    <= '0;
            wr_spec_q  <= '0;
            wr_com_q   <= '0;
            desc_wr_q  <= '0;
            drop_cnt   <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            tuser_q    <= tuser_d;
            wr_spec_q  <= wr_spec_d;
            wr_com_q   <= wr_com_d;
            rst_done_q <= 1'b1;
            if (desc_we) begin
                desc_wr_q <= desc_wr_q + (LAw + 1)'(1);
            end
            if (drop_inc) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (data_we) begin
            data_mem[wr_spec_q[DAw-1:0]] <= {s_axis.tdata, s_axis.tstrb, s_axis.tlast};
        end
        if (desc_we) begin
            desc_mem[desc_wr_q[LAw-1:0]] <= desc_wdata;
        end
    end

    // desc_ld tracks the descriptor for the beat being loaded; desc_rd frees the slot only once
    // the packet's last beat has actually left, so descriptor-full reflects unsent packets.
    assign rd_entry = data_mem[rd_q[DAw-1:0]];
    assign load     = desc_avail & ~data_empty & (~m_valid_q | m_axis.tready);
    assign out_pop  = m_valid_q & m_axis.tready & m_last_q;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rd_q      <= '0;
            desc_ld_q <= '0;
            desc_rd_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_strb_q  <= '0;
            m_user_q  <= '0;
        end else begin
            if (out_pop) begin
                desc_rd_q <= desc_rd_q + (LAw + 1)'(1);
            end
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= rd_entry[EntryW-1 -: C_AXIS_DATA_WIDTH];
                m_strb_q  <= rd_entry[StrbW:1];
                m_last_q  <= rd_entry[0];
                m_user_q  <= desc_mem[desc_ld_q[LAw-1:0]];
                rd_q      <= rd_q + (DAw + 1)'(1);
                if (rd_entry[0]) begin
                    desc_ld_q <= desc_ld_q + (LAw + 1)'(1);
                end
            end else if (m_axis.tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tstrb  = m_strb_q;
    assign m_axis.tuser  = m_user_q;

endmodule

// File: tb/tb_nf10_rx_len_stamper.sv
// Randomised bench for nf10_rx_len_stamper against a packet-level reference model.
module tb_nf10_rx_len_stamper;
    localparam int unsigned DW   = 256;
    localparam int unsigned TW   = 128;
    localparam int unsigned MAXB = 48;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        logic            l;
        logic [TW-1:0]   u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int exp_drop = 0;
    int rdy_mode = 1;

    beat_t exp_q[$];
    int    out_cyc[$];

    nf10_rx_len_stamper_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) s_if ();
    nf10_rx_len_stamper_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) m_if ();

    nf10_rx_len_stamper #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(TW),
        .C_DATA_FIFO_DEPTH (64),
        .C_LEN_FIFO_DEPTH  (16),
        .C_MAX_PKT_BEATS   (MAXB)
    ) dut (
        .axi_aclk (clk),
        .axi_reset(rst),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        case (rdy_mode)
            0:       m_if.tready = 1'b0;
            1:       m_if.tready = 1'b1;
            default: m_if.tready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #2;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [TW-1:0] rand_user();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output scoreboard plus a stability check while the sink is stalling.
    always @(negedge clk) begin : mon
        beat_t e;
        beat_t hold_b;
        logic  hold_pend;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", DW'(m_if.tvalid), DW'(1));
                check("hold_data", m_if.tdata, hold_b.d);
                check("hold_user", DW'(m_if.tuser), DW'(hold_b.u));
            end
            if (m_if.tvalid && m_if.tready) begin
                n_out++;
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", DW'(m_if.tvalid), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_if.tdata, e.d);
                    check("out_strb", DW'(m_if.tstrb), DW'(e.s));
                    check("out_last", DW'(m_if.tlast), DW'(e.l));
                    check("out_tuser", DW'(m_if.tuser), DW'(e.u));
                end
            end
            hold_pend = m_if.tvalid && !m_if.tready;
            hold_b.d  = m_if.tdata;
            hold_b.u  = m_if.tuser;
        end
    end

    task automatic in_idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_beat(input beat_t x, output int stalls);
        logic acc;
        acc    = 1'b0;
        stalls = 0;
        s_if.tdata  = x.d;
        s_if.tstrb  = x.s;
        s_if.tlast  = x.l;
        s_if.tuser  = x.u;
        s_if.tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stalls++;
                if (stalls > 3000) begin
                    check("in_timeout", DW'(s_if.tready), DW'(1));
                    return;
                end
            end
        end
    endtask

    // Reference: length is the total of set strobe bits; packets beyond MAXB beats vanish.
    task automatic send_pkt(input int nb, input logic rnd_strb, input logic [31:0] last_strb,
                            input logic [TW-1:0] tu, output int stalls);
        beat_t       b[$];
        beat_t       x;
        logic [15:0] len;
        int          st;
        len    = 16'd0;
        stalls = 0;
        for (int i = 0; i < nb; i++) begin
            x.d = rand_data();
            if (rnd_strb) x.s = $urandom;
            else          x.s = (i == nb - 1) ? last_strb : 32'hFFFF_FFFF;
            x.l = (i == nb - 1);
            x.u = (i == 0) ? tu : rand_user();
            len = len + 16'($countones(x.s));
            b.push_back(x);
        end
        if (nb > int'(MAXB)) begin
            exp_drop++;
        end else begin
            for (int i = 0; i < nb; i++) begin
                x   = b[i];
                x.u = {tu[TW-1:16], len};
                exp_q.push_back(x);
            end
        end
        for (int i = 0; i < nb; i++) begin
            send_beat(b[i], st);
            stalls += st;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(tag, DW'(exp_q.size()), DW'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int          st;
        int          tot;
        int          n0;
        logic [TW-1:0] tu;
        beat_t       x;

        in_idle();
        s_if.tdata = '0;
        s_if.tstrb = '0;
        s_if.tuser = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", DW'(s_if.tready), DW'(0));
        check("rst_m_tvalid", DW'(m_if.tvalid), DW'(0));
        check("rst_m_tlast", DW'(m_if.tlast), DW'(0));
        check("rst_m_tdata", m_if.tdata, DW'(0));
        check("rst_m_tstrb", DW'(m_if.tstrb), DW'(0));
        check("rst_m_tuser", DW'(m_if.tuser), DW'(0));
        check("rst_drop_cnt", DW'(drop_cnt), DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk) check("rdy_first_cycle", DW'(s_if.tready), DW'(0));
        @(negedge clk) check("rdy_after_reset", DW'(s_if.tready), DW'(1));
        @(posedge clk);
        #1;

        // 64-byte packet, latency check
        tu = rand_user();
        tu[23:16] = 8'h10;
        send_pkt(2, 1'b0, 32'hFFFF_FFFF, tu, st);
        in_idle();
        @(negedge clk) check("lat_after_commit", DW'(m_if.tvalid), DW'(0));
        @(negedge clk) check("lat_after_read", DW'(m_if.tvalid), DW'(1));
        @(posedge clk);
        #1;
        wait_drain("pkt64_drain");

        // 65-byte packet
        send_pkt(3, 1'b0, 32'h0000_0001, rand_user(), st);
        in_idle();
        wait_drain("pkt65_drain");

        // Oversize packet followed by a normal one
        tot = 0;
        send_pkt(60, 1'b0, 32'hFFFF_FFFF, rand_user(), st);
        tot += st;
        send_pkt(2, 1'b0, 32'hFFFF_FFFF, rand_user(), st);
        tot += st;
        in_idle();
        check("drop_no_stall", DW'(tot), DW'(0));
        wait_drain("drop_drain");
        check("drop_cnt_one", DW'(drop_cnt), DW'(exp_drop));

        // Descriptor FIFO fill with sink stalled
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            send_pkt(1, 1'b1, 32'hFFFF_FFFF, rand_user(), st);
            tot += st;
        end
        in_idle();
        check("fill_no_stall", DW'(tot), DW'(0));
        @(negedge clk) check("rdy_desc_full", DW'(s_if.tready), DW'(0));
        @(posedge clk);
        #1;
        fork
            begin
                repeat (6) @(posedge clk);
                rdy_mode = 1;
            end
            begin
                send_pkt(1, 1'b1, 32'hFFFF_FFFF, rand_user(), st);
            end
        join
        in_idle();
        check("pkt17_stalled", DW'(st > 3), DW'(1));
        wait_drain("fill_drain");

        // 1-beat and 4-beat packets stored, then drained with no gap
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        send_pkt(1, 1'b0, 32'h0000_00FF, rand_user(), st);
        send_pkt(4, 1'b0, 32'hFFFF_FFFF, rand_user(), st);
        in_idle();
        repeat (4) @(posedge clk);
        out_cyc.delete();
        rdy_mode = 1;
        wait_drain("b2b_drain");
        check("b2b_count", DW'(out_cyc.size()), DW'(5));
        if (out_cyc.size() >= 5) check("b2b_span", DW'(out_cyc[4] - out_cyc[0]), DW'(4));

        // Reset during beat 2 of a 3-beat packet
        n0  = n_out;
        x.d = rand_data();
        x.s = 32'hFFFF_FFFF;
        x.l = 1'b0;
        x.u = rand_user();
        send_beat(x, st);
        s_if.tdata = rand_data();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_idle();
        exp_drop = 0;
        @(negedge clk) check("rst_mid_rdy_low", DW'(s_if.tready), DW'(0));
        @(negedge clk) check("rst_mid_rdy_high", DW'(s_if.tready), DW'(1));
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_output", DW'(n_out), DW'(n0));
        check("rst_drop_cnt_clear", DW'(drop_cnt), DW'(0));
        send_pkt(3, 1'b0, 32'h0000_FFFF, rand_user(), st);
        in_idle();
        wait_drain("post_rst_drain");

        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 56), 1'b1, 32'hFFFF_FFFF, rand_user(), st);
            if ($urandom_range(0, 1) == 1) begin
                in_idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_idle();
        rdy_mode = 1;
        wait_drain("rand_drain");
        check("rand_drop_cnt", DW'(drop_cnt), DW'(exp_drop));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
